xm_pipe_stage: RTL and testbench

Parametrised execute/memory pipeline boundary register. It carries the ALU result (O), store operand (B) and instruction (IR) fields, and adds a per-stage valid bit, a valid/ready handshake, an optional 2-entry skid buffer, and flush-to-bubble. It sits between the execute and memory stages and is the template for the other inter-stage registers.

---
 rtl/xm_pipe_pkg.sv | 35 +++
 rtl/pipe_field_reg.sv | 21 ++
 rtl/xm_pipe_stage.sv | 129 ++++++++++++
 tb/tb_xm_pipe_stage.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/xm_pipe_pkg.sv
// Shared types for the execute/memory boundary register: stage state, default bubble
// instruction and the beat layout at the default field widths.
package xm_pipe_pkg;

    typedef enum logic [1:0] {
        StEmpty    = 2'd0,
        StFull     = 2'd1,
        StSkidFull = 2'd2
    } xm_state_e;

    localparam int unsigned DefDataW = 32;
    localparam int unsigned DefIrW   = 32;

    localparam logic [DefIrW-1:0] NopIrDefault = '0;

    typedef struct packed {
        logic                valid;
        logic [DefDataW-1:0] o;
        logic [DefDataW-1:0] b;
        logic [DefIrW-1:0]   ir;
    } xm_beat_t;

    function automatic logic [1:0] state_occupancy(input xm_state_e s);
        logic [1:0] occ;
        occ = 2'd0;
        unique case (s)
            StEmpty:    occ = 2'd0;
            StFull:     occ = 2'd1;
            StSkidFull: occ = 2'd2;
            default:    occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_field_reg.sv
// Width-parametrised register with load enable and a synchronous clear to a fixed value.
module pipe_field_reg #(
    parameter int unsigned W       = 8,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clear) begin
            q <= CLR_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/xm_pipe_stage.sv
// Execute/memory pipeline boundary register with valid/ready handshake, optional
// two-entry skid buffer and flush-to-bubble.
module xm_pipe_stage
    import xm_pipe_pkg::*;
#(
    parameter int unsigned      DATA_W = 32,
    parameter int unsigned      IR_W   = 32,
    parameter logic [IR_W-1:0]  NOP_IR = NopIrDefault,
    parameter int unsigned      SKID   = 1
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] o_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic [IR_W-1:0]   ir_in,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] o_out,
    output logic [DATA_W-1:0] b_out,
    output logic [IR_W-1:0]   ir_out,
    output logic [1:0]        occupancy
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] o;
        logic [DATA_W-1:0] b;
        logic [IR_W-1:0]   ir;
    } beat_t;

    localparam int unsigned BEAT_W = $bits(beat_t);
    localparam beat_t BUBBLE = '{valid: 1'b0, o: '0, b: '0, ir: NOP_IR};

    beat_t     main_q, main_d, skid_q, skid_d, in_beat;
    logic      main_load, skid_load, kill;
    logic      in_fire, out_fire, in_ready_q;
    xm_state_e state_q, state_d;

    assign kill      = clear | flush;
    assign out_valid = main_q.valid;
    // Registered ready keeps out_ready off the upstream timing path in skid mode.
    assign in_ready  = (SKID != 0) ? in_ready_q : (!main_q.valid || out_ready);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        in_beat   = '{valid: 1'b1, o: o_in, b: b_in, ir: ir_in};
        main_d    = in_beat;
        main_load = 1'b0;
        skid_d    = in_beat;
        skid_load = 1'b0;
        state_d   = state_q;
        unique case (state_q)
            StEmpty: begin
                if (in_fire) begin
                    main_load = 1'b1;
                    state_d   = StFull;
                end
            end
            StFull: begin
                if (in_fire && out_fire) begin
                    main_load = 1'b1;
                end else if (in_fire) begin
                    skid_load = 1'b1;
                    state_d   = StSkidFull;
                end else if (out_fire) begin
                    main_d    = BUBBLE;
                    main_load = 1'b1;
                    state_d   = StEmpty;
                end
            end
            StSkidFull: begin
                if (out_fire) begin
                    main_d    = skid_q;
                    main_load = 1'b1;
                    skid_d    = BUBBLE;
                    skid_load = 1'b1;
                    state_d   = StFull;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear || flush) begin
            state_q    <= StEmpty;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != StSkidFull);
        end
    end

    pipe_field_reg #(
        .W       (BEAT_W),
        .CLR_VAL (BUBBLE)
    ) u_main_reg (
        .clk   (clk),
        .clear (kill),
        .load  (main_load),
        .d     (main_d),
        .q     (main_q)
    );

    if (SKID != 0) begin : g_skid
        pipe_field_reg #(
            .W       (BEAT_W),
            .CLR_VAL (BUBBLE)
        ) u_skid_reg (
            .clk   (clk),
            .clear (kill),
            .load  (skid_load),
            .d     (skid_d),
            .q     (skid_q)
        );
    end else begin : g_no_skid
        assign skid_q = BUBBLE;
    end

    assign o_out     = main_q.o;
    assign b_out     = main_q.b;
    assign ir_out    = main_q.ir;
    assign occupancy = state_occupancy(state_q);

endmodule

// File: tb/tb_xm_pipe_stage.sv
// Self-checking bench: a skid-buffered stage and a plain single-register stage share
// stimulus; each is compared against a bounded-FIFO model of the handshake.
module tb_xm_pipe_stage;

    localparam logic [31:0] NOP0 = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] o;
        logic [31:0] b;
        logic [31:0] ir;
    } mbeat_t;

    logic        clk = 1'b0;
    logic        clear = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] o_in = '0, b_in = '0, ir_in = '0;

    logic        in_ready1, out_valid1, in_ready0, out_valid0;
    logic [31:0] o_out1, b_out1, ir_out1, o_out0, b_out0, ir_out0;
    logic [1:0]  occ1, occ0;

    mbeat_t q1[$];
    mbeat_t q0[$];
    int     n_checks = 0;
    int     n_fail = 0;
    bit     seen99 = 1'b0;

    always #5 clk = ~clk;

    xm_pipe_stage #(.DATA_W(32), .IR_W(32), .NOP_IR(32'h0), .SKID(1)) u_dut_skid (
        .clk       (clk),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .o_in      (o_in),
        .b_in      (b_in),
        .ir_in     (ir_in),
        .flush     (flush),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .o_out     (o_out1),
        .b_out     (b_out1),
        .ir_out    (ir_out1),
        .occupancy (occ1)
    );

    xm_pipe_stage #(.DATA_W(32), .IR_W(32), .NOP_IR(NOP0), .SKID(0)) u_dut_plain (
        .clk       (clk),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready0),
        .o_in      (o_in),
        .b_in      (b_in),
        .ir_in     (ir_in),
        .flush     (flush),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .o_out     (o_out0),
        .b_out     (b_out0),
        .ir_out    (ir_out0),
        .occupancy (occ0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check ready before the edge, advance both models, check outputs after.
    task automatic tick();
        bit     f1_in, f1_out, f0_in, f0_out;
        mbeat_t nb;
        #1;
        chk("s1_in_ready", {31'b0, in_ready1}, {31'b0, q1.size() < 2});
        chk("s0_in_ready", {31'b0, in_ready0}, {31'b0, (q0.size() == 0) || out_ready});
        f1_in  = in_valid && (q1.size() < 2);
        f1_out = (q1.size() > 0) && out_ready;
        f0_in  = in_valid && ((q0.size() == 0) || out_ready);
        f0_out = (q0.size() > 0) && out_ready;
        nb = '{o: o_in, b: b_in, ir: ir_in};
        @(posedge clk);
        if (clear || flush) begin
            q1.delete();
            q0.delete();
        end else begin
            if (f1_out) void'(q1.pop_front());
            if (f1_in) q1.push_back(nb);
            if (f0_out) void'(q0.pop_front());
            if (f0_in) q0.push_back(nb);
        end
        #1;
        chk("s1_out_valid", {31'b0, out_valid1}, {31'b0, q1.size() > 0});
        chk("s1_o_out", o_out1, (q1.size() > 0) ? q1[0].o : 32'h0);
        chk("s1_b_out", b_out1, (q1.size() > 0) ? q1[0].b : 32'h0);
        chk("s1_ir_out", ir_out1, (q1.size() > 0) ? q1[0].ir : 32'h0);
        chk("s1_occupancy", {30'b0, occ1}, q1.size());
        chk("s0_out_valid", {31'b0, out_valid0}, {31'b0, q0.size() > 0});
        chk("s0_o_out", o_out0, (q0.size() > 0) ? q0[0].o : 32'h0);
        chk("s0_b_out", b_out0, (q0.size() > 0) ? q0[0].b : 32'h0);
        chk("s0_ir_out", ir_out0, (q0.size() > 0) ? q0[0].ir : NOP0);
        chk("s0_occupancy", {30'b0, occ0}, q0.size());
        if ((out_valid1 && o_out1 == 32'd99) || (out_valid0 && o_out0 == 32'd99)) seen99 = 1'b1;
    endtask

    task automatic beat(input logic [31:0] o);
        in_valid = 1'b1;
        o_in     = o;
        b_in     = $urandom | 32'h1000;
        ir_in    = $urandom;
    endtask

    initial begin
        // Reset with a live beat on the input
        clear = 1'b1; in_valid = 1'b1; ir_in = 32'hDEAD_BEEF; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clear = 1'b0; in_valid = 1'b0;
        tick();
        chk("rst_out_valid", {31'b0, out_valid1}, 32'd0);
        chk("rst_ir_out", ir_out1, 32'h0);
        chk("rst_occupancy", {30'b0, occ1}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready1}, 32'd1);
        chk("rst_s0_ir_out", ir_out0, NOP0);

        // Back-to-back streaming
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            beat(i);
            tick();
            chk("stream_valid", {31'b0, out_valid1}, 32'd1);
            chk("stream_o", o_out1, i);
            chk("stream_o_s0", o_out0, i);
        end
        in_valid = 1'b0;
        tick();

        // Backpressure
        beat(10); tick();
        out_ready = 1'b0; beat(11);
        #1;
        chk("s0_ready_drops", {31'b0, in_ready0}, 32'd0);
        tick();
        beat(12); tick();
        chk("bp_occupancy", {30'b0, occ1}, 32'd2);
        chk("bp_in_ready", {31'b0, in_ready1}, 32'd0);
        chk("bp_hold", o_out1, 32'd10);
        chk("bp_hold_s0", o_out0, 32'd10);
        out_ready = 1'b1;
        #1;
        chk("s0_ready_rises", {31'b0, in_ready0}, 32'd1);
        tick();
        chk("bp_drain_11", o_out1, 32'd11);
        chk("s0_load_as_leave", o_out0, 32'd12);
        tick();
        chk("bp_drain_12", o_out1, 32'd12);
        in_valid = 1'b0;
        tick(); tick();

        // Flush from SKID_FULL with a beat on the input
        out_ready = 1'b1; beat(20); tick();
        out_ready = 1'b0; beat(21); tick();
        flush = 1'b1; beat(99); tick();
        chk("flush_valid", {31'b0, out_valid1}, 32'd0);
        chk("flush_ir", ir_out1, 32'h0);
        chk("flush_occupancy", {30'b0, occ1}, 32'd0);
        chk("flush_in_ready", {31'b0, in_ready1}, 32'd1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        // Flush while FULL with both handshakes firing
        beat(30); tick();
        flush = 1'b1; beat(98); tick();
        chk("flush_full_valid", {31'b0, out_valid1}, 32'd0);
        flush = 1'b0; in_valid = 1'b0;
        tick();

        // Clear under backpressure
        out_ready = 1'b1; beat(40); tick();
        out_ready = 1'b0; beat(41); tick();
        chk("clr_pre_occ", {30'b0, occ1}, 32'd2);
        clear = 1'b1; beat(77); tick();
        chk("clr_valid", {31'b0, out_valid1}, 32'd0);
        chk("clr_o", o_out1, 32'd0);
        chk("clr_b", b_out1, 32'd0);
        chk("clr_ir", ir_out1, 32'h0);
        chk("clr_occ", {30'b0, occ1}, 32'd0);
        chk("clr_in_ready", {31'b0, in_ready1}, 32'd1);
        clear = 1'b0; out_ready = 1'b1; beat(42); tick();
        chk("clr_next_valid", {31'b0, out_valid1}, 32'd1);
        chk("clr_next_o", o_out1, 32'd42);
        in_valid = 1'b0;
        tick();

        // Randomised traffic with occasional flush/clear
        for (int n = 0; n < 400; n++) begin
            beat($urandom | 32'h1000);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            clear     = ($urandom_range(0, 31) == 0);
            tick();
        end
        flush = 1'b0; clear = 1'b0;

        chk("dropped_99_never_seen", {31'b0, seen99}, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
